// File: rtl/qnigma_rng_pool.sv
// qnigma_rng_pool: buffered random-word source fed by the LFSR generator.
// Samples prng_res once every DECIM cycles into a DEPTH-entry first-word-fall-through
// FIFO and hands words out over a valid/ready port.
// Optional feature macro: QNIGMA_RNG_HEALTH_EN. When it is defined, a repetition health
// test is built in. The test latches err, flushes the FIFO and blocks further pushes
// until reset. When it is undefined, err is tied low and no compare logic exists.
module qnigma_rng_pool #(
    parameter int W         = 32,
    parameter int DEPTH     = 4,
    parameter int DECIM     = 32,
    parameter int REP_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               prng_res,
    input  logic                       rd_req,
    output logic                       rd_val,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err
);

    localparam int CW = $clog2(DECIM) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_NEAR = LW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_NONEMPTY = 2'd1,
        ST_FULL     = 2'd2
`ifdef QNIGMA_RNG_HEALTH_EN
        , ST_FAULT  = 2'd3
`endif
    } state_t;

`ifdef QNIGMA_RNG_HEALTH_EN
    localparam state_t ST_TRIP = ST_FAULT;
`else
    localparam state_t ST_TRIP = ST_EMPTY;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [W-1:0]    rd_dat_q, rd_dat_d;
    logic [W-1:0]    mem_q [DEPTH];

    logic            strobe_s;
    logic            pop_s;
    logic            push_s;
    logic            trip_s;
    logic            rd_val_s;
    logic            err_s;

    assign strobe_s = (cnt_q == CNT_LAST);
    assign pop_s    = rd_val_s && rd_req;
    assign push_s   = strobe_s && !err_s && !trip_s && ((level_q != LVL_FULL) || pop_s);

`ifdef QNIGMA_RNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT) + 1;
    localparam logic [RW-1:0] REP_TRIP = RW'(REP_LIMIT - 2);

    logic [W-1:0]    prev_q;
    logic            prev_vld_q;
    logic [RW-1:0]   rep_q, rep_d;
    logic            match_s;

    // Health compare: a strobed sample equal to the previous strobed sample is a repeat.
    always_comb begin
        match_s = strobe_s && prev_vld_q && (prng_res == prev_q);
        trip_s  = match_s && (rep_q == REP_TRIP) && !err_s;
        if (match_s) begin
            rep_d = rep_q + RW'(1);
        end else begin
            rep_d = {RW{1'b0}};
        end
    end

    // Health state: remember the last strobed sample and the current run of repeats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q     <= {W{1'b0}};
            prev_vld_q <= 1'b0;
            rep_q      <= {RW{1'b0}};
        end else if (strobe_s && !err_s) begin
            prev_q     <= prng_res;
            prev_vld_q <= 1'b1;
            rep_q      <= rep_d;
        end else begin
            prev_q     <= prev_q;
            prev_vld_q <= prev_vld_q;
            rep_q      <= rep_q;
        end
    end
`else
    assign trip_s = 1'b0;
`endif

    // Datapath next state: decimation counter, pointers, level and the presented head word.
    always_comb begin
        if (strobe_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (push_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        if (trip_s) begin
            level_d = {LW{1'b0}};
        end else if (push_s && !pop_s) begin
            level_d = level_q + LW'(1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
        // The word being written this edge is not yet in storage, so forward it when it
        // lands exactly at the new read pointer.
        if (push_s && (wptr_q == rptr_d)) begin
            rd_dat_d = prng_res;
        end else begin
            rd_dat_d = mem_q[rptr_d];
        end
    end

    // FIFO storage write; storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_q[wptr_q] <= prng_res;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= {CW{1'b0}};
            wptr_q   <= {PW{1'b0}};
            rptr_q   <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            rd_dat_q <= {W{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    // FIFO state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO next-state logic; a health trip overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (trip_s) begin
                    state_d = ST_TRIP;
                end else if (push_s) begin
                    state_d = ST_NONEMPTY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_NONEMPTY: begin
                if (trip_s) begin
                    state_d = ST_TRIP;
                end else if (push_s && !pop_s && (level_q == LVL_NEAR)) begin
                    state_d = ST_FULL;
                end else if (pop_s && !push_s && (level_q == LVL_ONE)) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_NONEMPTY;
                end
            end
            ST_FULL: begin
                if (trip_s) begin
                    state_d = ST_TRIP;
                end else if (pop_s && !push_s) begin
                    state_d = ST_NONEMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
`ifdef QNIGMA_RNG_HEALTH_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output decode from the registered FIFO state.
    always_comb begin
        rd_val_s = (state_q == ST_NONEMPTY) || (state_q == ST_FULL);
`ifdef QNIGMA_RNG_HEALTH_EN
        err_s    = (state_q == ST_FAULT);
`else
        err_s    = 1'b0;
`endif
    end

    assign rd_val = rd_val_s;
    assign rd_dat = rd_dat_q;
    assign level  = level_q;
    assign err    = err_s;

endmodule

// File: tb/tb_qnigma_rng_pool.sv
// Self-checking bench for qnigma_rng_pool: two instances (DECIM=4 and DECIM=1) share the
// stimulus and are compared every cycle against a queue-based reference model.
module tb_qnigma_rng_pool;

    localparam int W         = 32;
    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  prng_res = 32'd0;
    logic          rd_req = 1'b0;

    logic          rd_val0, rd_val1, err0, err1;
    logic [W-1:0]  rd_dat0, rd_dat1;
    logic [2:0]    level0, level1;

    int n_vec  = 0;
    int n_fail = 0;

    // model state per instance
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          cyc[2];
    bit          have_prev[2];
    logic [31:0] prev[2];
    int          run[2];
    bit          fault[2];

    always #5 clk = ~clk;

    qnigma_rng_pool #(.W(W), .DEPTH(DEPTH), .DECIM(4), .REP_LIMIT(REP_LIMIT)) u_dut0 (
        .clk(clk), .rst(rst), .prng_res(prng_res), .rd_req(rd_req),
        .rd_val(rd_val0), .rd_dat(rd_dat0), .level(level0), .err(err0)
    );

    qnigma_rng_pool #(.W(W), .DEPTH(DEPTH), .DECIM(1), .REP_LIMIT(REP_LIMIT)) u_dut1 (
        .clk(clk), .rst(rst), .prng_res(prng_res), .rd_req(rd_req),
        .rd_val(rd_val1), .rd_dat(rd_dat1), .level(level1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model for instance k with sample period decim.
    task automatic model_edge(input int k, input int decim, input logic r,
                              input logic [31:0] p, input logic req);
        logic [31:0] q[$];
        bit strobe, pop, push, trip;
        if (k == 0) q = q0; else q = q1;
        if (!r) begin
            q.delete();
            cyc[k] = 0; fault[k] = 0; have_prev[k] = 0; run[k] = 0;
        end else begin
            strobe = ((cyc[k] % decim) == decim - 1);
            cyc[k]++;
            pop  = (q.size() != 0) && req;
            trip = 0;
            if (strobe && !fault[k]) begin
                if (have_prev[k] && p == prev[k]) run[k]++; else run[k] = 1;
                have_prev[k] = 1;
                prev[k] = p;
`ifdef QNIGMA_RNG_HEALTH_EN
                if (run[k] >= REP_LIMIT) begin
                    trip = 1;
                    fault[k] = 1;
                end
`endif
            end
            push = strobe && !fault[k] && ((q.size() < DEPTH) || pop);
            if (trip) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(p);
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic compare_dut(input int k, input logic r, input logic v, input logic [31:0] d,
                               input logic [2:0] l, input logic e);
        logic [31:0] q[$];
        if (k == 0) q = q0; else q = q1;
        check($sformatf("rd_val%0d", k), {31'd0, v}, {31'd0, (q.size() != 0)});
        check($sformatf("level%0d", k), {29'd0, l}, q.size());
        check($sformatf("err%0d", k), {31'd0, e}, {31'd0, fault[k]});
        if (!r) check($sformatf("rd_dat_rst%0d", k), d, 32'd0);
        else if (q.size() != 0) check($sformatf("rd_dat%0d", k), d, q[0]);
    endtask

    task automatic step(input logic r, input logic [31:0] p, input logic req);
        rst = r; prng_res = p; rd_req = req;
        @(posedge clk);
        model_edge(0, 4, r, p, req);
        model_edge(1, 1, r, p, req);
        #1;
        compare_dut(0, r, rd_val0, rd_dat0, level0, err0);
        compare_dut(1, r, rd_val1, rd_dat1, level1, err1);
    endtask

    initial begin
        logic [31:0] rv;
        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 32'hDEAD_0000 + i, 1'b1);
        // fill with counting stimulus, no reads
        for (int i = 0; i < 24; i++) begin
            step(1'b1, i, 1'b0);
            if (i == 3) begin
                check("first_val", {31'd0, rd_val0}, 32'd1);
                check("first_dat", rd_dat0, 32'd3);
            end
        end
        check("full_level", {29'd0, level0}, 32'd4);
        // pop exactly in a strobe cycle while full
        for (int i = 24; i < 32; i++) step(1'b1, i, (i == 27));
        check("full_pop_level", {29'd0, level0}, 32'd4);
        // continuous reads
        for (int i = 32; i < 52; i++) step(1'b1, i, 1'b1);
        // randomized traffic with occasional stuck stretches and resets
        rv = $urandom;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) rv = $urandom;
            step(($urandom_range(0, 199) != 0), rv, ($urandom_range(0, 1) == 1));
        end
        // reset mid-stream with level 3 and a read pending
        step(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, i, 1'b0);
        check("pre_rst_level", {29'd0, level0}, 32'd3);
        step(1'b0, 32'd99, 1'b1);
        check("rst_val", {31'd0, rd_val0}, 32'd0);
        check("rst_dat", rd_dat0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h100 + i, 1'b0);
            if (i == 3) check("post_rst_dat", rd_dat0, 32'h103);
        end
        // stuck generator
        step(1'b0, 32'h0000_00AA, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 32'h0000_00AA, 1'b0);
`ifdef QNIGMA_RNG_HEALTH_EN
        check("stuck_err", {31'd0, err0}, 32'd1);
        check("stuck_level", {29'd0, level0}, 32'd0);
`else
        check("stuck_err", {31'd0, err0}, 32'd0);
        check("stuck_level", {29'd0, level0}, 32'd4);
        check("stuck_dat", rd_dat0, 32'h0000_00AA);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
